// File: rtl/ppu_frame_writer.sv
// ppu_frame_writer: palette-maps PPU pixels, packs 4 shades per byte, writes a double-buffered framebuffer
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   lcd_en               LCDC[7]; low aborts the frame in progress
//   ppu_mode, px_in,     PPU mode (0 HBLANK, 1 VBLANK, 2 SCAN, 3 DRAW), colour index,
//   px_valid             and its valid strobe
//   bgp, err_clr         palette, sticky-error clear pulse
//   fb_we/addr/wdata     framebuffer byte write port (leftmost pixel in [7:6])
//   disp_bank            bank holding the last completed frame
//   frame_done           one-cycle pulse on a completed frame hand-over
//   err                  sticky {short frame, short line, pixel overflow}
module ppu_frame_writer #(
    parameter int WIDTH   = 160,
    parameter int HEIGHT  = 144,
    parameter int BANK_SZ = WIDTH * HEIGHT / 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_en,
    input  logic [1:0]  ppu_mode,
    input  logic [1:0]  px_in,
    input  logic        px_valid,
    input  logic [7:0]  bgp,
    input  logic        err_clr,
    output logic        fb_we,
    output logic [13:0] fb_addr,
    output logic [7:0]  fb_wdata,
    output logic        disp_bank,
    output logic        frame_done,
    output logic [2:0]  err
);
    localparam logic [7:0]  W    = 8'(WIDTH);
    localparam logic [7:0]  H    = 8'(HEIGHT);
    localparam logic [13:0] ROW  = 14'(WIDTH / 4);
    localparam logic [13:0] BANK = 14'(BANK_SZ);

    typedef enum logic [1:0] {WAIT_FRAME, DRAW_LINE, LINE_GAP} state_t;

    state_t      state, state_n;
    logic [1:0]  mode_q;
    logic [7:0]  x, y, pack;
    logic        wr_bank;
    logic        pend_v;
    logic [13:0] pend_addr;
    logic [7:0]  pend_data;

    logic        line_end, frame_end, accept, ovf, pix_wr, flush;
    logic [1:0]  shade, pad;
    logic [7:0]  x_a, pack_a, flush_data;
    logic [13:0] row_base, pix_addr, flush_addr;
    logic [2:0]  err_set;

    always_comb begin
        line_end   = lcd_en && state == DRAW_LINE && mode_q == 2'd3 && ppu_mode == 2'd0;
        frame_end  = lcd_en && state != WAIT_FRAME && mode_q != 2'd1 && ppu_mode == 2'd1;
        accept     = lcd_en && px_valid && state == DRAW_LINE && x < W && y < H;
        ovf        = lcd_en && px_valid && state == DRAW_LINE && x == W;
        shade      = bgp[{px_in, 1'b0} +: 2];
        x_a        = accept ? x + 8'd1 : x;
        pack_a     = accept ? {pack[5:0], shade} : pack;
        pix_wr     = accept && x[1:0] == 2'd3;
        // a pixel arriving with the line-end edge is packed first, so the flush sees x_a
        flush      = line_end && x_a[1:0] != 2'd0;
        pad        = 2'd0 - x_a[1:0];
        flush_data = pack_a << {pad, 1'b0};
        row_base   = (wr_bank ? BANK : 14'd0) + 14'(y) * ROW;
        pix_addr   = row_base + 14'(x[7:2]);
        flush_addr = row_base + 14'(x_a[7:2]);
        err_set    = {frame_end && y != H, line_end && x_a != W, ovf};
        state_n    = (!lcd_en || frame_end) ? WAIT_FRAME :
                     line_end ? LINE_GAP :
                     (state != DRAW_LINE && ppu_mode == 2'd3) ? DRAW_LINE : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WAIT_FRAME;
            mode_q     <= 2'd0;
            x          <= 8'd0;
            y          <= 8'd0;
            pack       <= 8'd0;
            wr_bank    <= 1'b0;
            pend_v     <= 1'b0;
            pend_addr  <= 14'd0;
            pend_data  <= 8'd0;
            fb_we      <= 1'b0;
            fb_addr    <= 14'd0;
            fb_wdata   <= 8'd0;
            disp_bank  <= 1'b0;
            frame_done <= 1'b0;
            err        <= 3'd0;
        end else begin
            state      <= state_n;
            mode_q     <= ppu_mode;
            err        <= (err & {3{~err_clr}}) | err_set;
            frame_done <= frame_end && y == H;
            fb_we      <= lcd_en && (pix_wr || flush || pend_v);
            // one write per cycle: the 4th-pixel byte wins, a coincident flush waits one cycle
            pend_v     <= pix_wr && flush;
            if (pix_wr || flush || pend_v) begin
                fb_addr  <= pix_wr ? pix_addr : flush ? flush_addr : pend_addr;
                fb_wdata <= pix_wr ? pack_a : flush ? flush_data : pend_data;
            end
            if (flush) begin
                pend_addr <= flush_addr;
                pend_data <= flush_data;
            end
            if (!lcd_en) begin
                x      <= 8'd0;
                y      <= 8'd0;
                pack   <= 8'd0;
                pend_v <= 1'b0;
            end else if (frame_end) begin
                x    <= 8'd0;
                y    <= 8'd0;
                pack <= 8'd0;
                if (y == H) begin
                    disp_bank <= wr_bank;
                    wr_bank   <= ~wr_bank;
                end
            end else if (line_end) begin
                x    <= 8'd0;
                y    <= (y == H) ? y : y + 8'd1;
                pack <= 8'd0;
            end else begin
                x    <= x_a;
                pack <= pack_a;
            end
        end
    end
endmodule

// File: tb/tb_ppu_frame_writer.sv
// tb_ppu_frame_writer: table-driven and randomized checks of ppu_frame_writer against a line-level model
module tb_ppu_frame_writer;
    logic        clk = 1'b0;
    logic        rst, lcd_en, px_valid, err_clr;
    logic [1:0]  ppu_mode, px_in;
    logic [7:0]  bgp;
    logic        fb_we, disp_bank, frame_done;
    logic [13:0] fb_addr;
    logic [7:0]  fb_wdata;
    logic [2:0]  err;

    always #5 clk = ~clk;

    ppu_frame_writer dut (
        .clk(clk), .rst(rst), .lcd_en(lcd_en), .ppu_mode(ppu_mode), .px_in(px_in),
        .px_valid(px_valid), .bgp(bgp), .err_clr(err_clr), .fb_we(fb_we), .fb_addr(fb_addr),
        .fb_wdata(fb_wdata), .disp_bank(disp_bank), .frame_done(frame_done), .err(err)
    );

    typedef struct {
        int         n;
        bit         coinc;
        bit         gaps;
        bit         pat;
        int         exp_wr;
        logic [2:0] exp_err;
    } vec_t;
    vec_t vt[7];

    logic [21:0] got_q[$];
    logic [21:0] exp_q[$];
    logic [1:0]  sh[0:199];
    int          done_cnt = 0;
    int          passed = 0;
    int          total = 0;
    int          m_y, exp_done;
    bit          m_bank, m_disp, m_in;
    logic [2:0]  m_err;

    always @(negedge clk) begin
        if (fb_we) got_q.push_back({fb_addr, fb_wdata});
        if (frame_done) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_line(input int n, input bit fl);
        int nb;
        logic [7:0] v;
        nb = fl ? (n + 3) / 4 : n / 4;
        for (int b = 0; b < nb; b++) begin
            v = 8'd0;
            for (int j = 0; j < 4; j++) if (4 * b + j < n) v[7 - 2 * j -: 2] = sh[4 * b + j];
            exp_q.push_back({14'(int'(m_bank) * 5760 + m_y * 40 + b), v});
        end
    endtask

    task automatic check_writes(input string name);
        int bad;
        bad = -1;
        chk({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
        total++;
        if (bad < 0) passed++;
        else $display("FAIL %s_data: entry %0d got %h expected %h", name, bad, got_q[bad], exp_q[bad]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic drive_line(input int n, input bit coinc, input bit gaps, input bit pat);
        int acc;
        ppu_mode = 2'd3;
        px_valid = 1'b0;
        tick();
        m_in = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(7) == 0) begin
                px_valid = 1'b0;
                tick();
            end
            px_in = pat ? 2'(i % 4) : 2'($urandom);
            if (!pat) bgp = 8'($urandom);
            if (i < 200) sh[i] = bgp[2 * px_in +: 2];
            px_valid = 1'b1;
            if (coinc && i == n - 1) ppu_mode = 2'd0;
            tick();
        end
        px_valid = 1'b0;
        ppu_mode = 2'd0;
        tick();
        tick();
        acc = n > 160 ? 160 : n;
        if (m_y < 144) begin
            model_line(acc, 1'b1);
            if (n > 160) m_err[0] = 1'b1;
            if (acc != 160) m_err[1] = 1'b1;
            m_y++;
        end
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_err = 3'd0;
    endtask

    task automatic vblank();
        ppu_mode = 2'd1;
        px_valid = 1'b0;
        tick();
        tick();
        tick();
        if (m_in) begin
            if (m_y == 144) begin
                exp_done++;
                m_disp = m_bank;
                m_bank = ~m_bank;
            end else m_err[2] = 1'b1;
        end
        m_in = 1'b0;
        m_y = 0;
    endtask

    function automatic int first_addr();
        return got_q.size() > 0 ? int'(got_q[0][21:8]) : -1;
    endfunction

    function automatic int last_entry();
        return got_q.size() > 0 ? int'(got_q[got_q.size() - 1]) : -1;
    endfunction

    initial begin
        int n, ok;
        rst = 1'b1; lcd_en = 1'b1; ppu_mode = 2'd1; px_in = 2'd0; px_valid = 1'b0;
        bgp = 8'hE4; err_clr = 1'b0;
        m_y = 0; exp_done = 0; m_bank = 0; m_disp = 0; m_in = 0; m_err = 3'd0;
        vt[0] = '{160, 1'b0, 1'b0, 1'b1, 40, 3'b000};
        vt[1] = '{162, 1'b0, 1'b0, 1'b0, 40, 3'b001};
        vt[2] = '{158, 1'b0, 1'b0, 1'b0, 40, 3'b010};
        vt[3] = '{160, 1'b1, 1'b0, 1'b0, 40, 3'b000};
        vt[4] = '{160, 1'b1, 1'b1, 1'b0, 40, 3'b000};
        vt[5] = '{157, 1'b1, 1'b1, 1'b0, 40, 3'b010};
        vt[6] = '{5,   1'b0, 1'b1, 1'b0, 2,  3'b010};
        #12;
        chk("rst_fb_we", fb_we, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_fb_wdata", fb_wdata, 0);
        chk("rst_disp_bank", disp_bank, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err", err, 0);
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) begin
            clear_err();
            if (vt[i].pat) bgp = 8'hE4;
            drive_line(vt[i].n, vt[i].coinc, vt[i].gaps, vt[i].pat);
            chk($sformatf("vec%0d_writes", i), got_q.size(), vt[i].exp_wr);
            chk($sformatf("vec%0d_err", i), err, vt[i].exp_err);
            if (vt[i].pat) begin
                ok = 1;
                foreach (got_q[k]) if (got_q[k] !== {14'(k), 8'h1B}) ok = 0;
                chk("line_bytes_1b", ok, 1);
            end
            if (vt[i].n == 158) chk("short_line_pad", last_entry() & 3, 0);
            if (vt[i].coinc && !vt[i].gaps && vt[i].n == 160)
                chk("coinc_last_addr", last_entry() >> 8, (m_y - 1) * 40 + 39);
            check_writes($sformatf("vec%0d", i));
        end
        clear_err();
        while (m_y < 144) begin
            n = ($urandom_range(7) == 0) ? int'($urandom_range(165, 150)) : 160;
            drive_line(n, 1'($urandom), 1'($urandom), 1'b0);
            check_writes($sformatf("f0_line%0d", m_y - 1));
        end
        chk("frame_err", err, m_err);
        vblank();
        chk("frame_done_cnt", done_cnt, exp_done);
        chk("frame_disp_bank", disp_bank, m_disp);
        clear_err();
        drive_line(160, 1'b0, 1'b0, 1'b0);
        chk("bank1_first_addr", first_addr(), 5760);
        check_writes("f1_line0");
        while (m_y < 100) begin
            drive_line(160, 1'($urandom), 1'($urandom), 1'b0);
            check_writes($sformatf("f1_line%0d", m_y - 1));
        end
        vblank();
        chk("short_frame_err2", err[2], 1);
        chk("short_frame_no_done", done_cnt, 1);
        chk("short_frame_disp", disp_bank, 0);
        drive_line(160, 1'b0, 1'b0, 1'b0);
        chk("bank_kept_addr", first_addr(), 5760);
        check_writes("f2_line0");
        while (m_y < 50) begin
            drive_line(160, 1'($urandom), 1'b0, 1'b0);
            check_writes($sformatf("f2_line%0d", m_y - 1));
        end
        ppu_mode = 2'd3;
        tick();
        for (int i = 0; i < 30; i++) begin
            px_in = 2'($urandom);
            px_valid = 1'b1;
            tick();
        end
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_fb_we", fb_we, 0);
        chk("midrst_fb_addr", fb_addr, 0);
        chk("midrst_fb_wdata", fb_wdata, 0);
        chk("midrst_err", err, 0);
        chk("midrst_frame_done", frame_done, 0);
        chk("pre_reset_writes", got_q.size(), 7);
        got_q.delete();
        exp_q.delete();
        px_valid = 1'b0;
        ppu_mode = 2'd0;
        m_y = 0; m_bank = 0; m_disp = 0; m_err = 3'd0; m_in = 0;
        tick();
        rst = 1'b0;
        tick();
        drive_line(160, 1'b0, 1'b0, 1'b0);
        chk("after_reset_addr", first_addr(), 0);
        check_writes("r_line0");
        drive_line(160, 1'b1, 1'b1, 1'b0);
        check_writes("r_line1");
        ppu_mode = 2'd3;
        tick();
        for (int i = 0; i < 41; i++) begin
            px_in = 2'($urandom);
            bgp = 8'($urandom);
            sh[i] = bgp[2 * px_in +: 2];
            px_valid = 1'b1;
            tick();
        end
        lcd_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            px_in = 2'($urandom);
            tick();
        end
        px_valid = 1'b0;
        ppu_mode = 2'd0;
        tick();
        tick();
        ppu_mode = 2'd1;
        tick();
        tick();
        tick();
        model_line(40, 1'b0);
        m_y = 0;
        m_in = 0;
        lcd_en = 1'b1;
        ppu_mode = 2'd0;
        tick();
        chk("lcd_off_writes", got_q.size(), 10);
        chk("lcd_off_no_done", done_cnt, exp_done);
        chk("lcd_off_err", err, m_err);
        chk("lcd_off_disp", disp_bank, m_disp);
        check_writes("lcd_off");
        drive_line(160, 1'b0, 1'b0, 1'b0);
        chk("after_lcd_addr", first_addr(), 0);
        check_writes("lcd_on_line0");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
